// File: rtl/wb_memory_slave.sv
// Wishbone classic-cycle slave memory: internal RAM with byte-lane writes and
// WAIT wait states between request capture and a single-cycle ack.
module wb_memory_slave #(
    parameter int WORD   = 16,
    parameter int MEM_AW = 10,
    parameter int WAIT   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cyc_i,
    input  logic                   stb_i,
    input  logic                   we_i,
    input  logic [WORD/8-1:0]      sel_i,
    input  logic [WORD-(WORD/8):0] adr_i,
    input  logic [WORD-1:0]        dat_i,
    output logic                   ack_o,
    output logic [WORD-1:0]        dat_o
);
    localparam int         LANES    = WORD / 8;
    localparam int         AW       = WORD - LANES + 1;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              we_r;
    logic [LANES-1:0]  sel_r;
    logic [AW-1:0]     adr_r;
    logic [WORD-1:0]   dat_r;
    logic [WORD-1:0]   mem_r [2**MEM_AW];

    logic              req_s;
    logic              go_ack_s;
    logic              cur_we_s;
    logic [LANES-1:0]  cur_sel_s;
    logic [AW-1:0]     cur_adr_s;
    logic [WORD-1:0]   cur_dat_s;
    logic              in_range_s;
    logic [MEM_AW-1:0] mem_idx_s;
    logic [WORD-1:0]   lane_mask_s;
    logic [WORD-1:0]   rd_word_s;

    function automatic logic [WORD-1:0] lane_mask(input logic [LANES-1:0] sel);
        logic [WORD-1:0] mask;
        mask = '0;
        for (int i = 0; i < LANES; i++) begin
            mask[i*8 +: 8] = {8{sel[i]}};
        end
        return mask;
    endfunction

    // Live bus inputs in IDLE (a zero-wait transfer completes on its capture edge), captured copy afterwards
    always_comb begin
        req_s = cyc_i & stb_i;
        if (state_r == ST_IDLE) begin
            cur_we_s  = we_i;
            cur_sel_s = sel_i;
            cur_adr_s = adr_i;
            cur_dat_s = dat_i;
        end else begin
            cur_we_s  = we_r;
            cur_sel_s = sel_r;
            cur_adr_s = adr_r;
            cur_dat_s = dat_r;
        end
        case (state_r)
            ST_IDLE: go_ack_s = req_s && (WAIT_CNT == 4'd0);
            ST_WAIT: go_ack_s = req_s && (cnt_r == 4'd1);
            default: go_ack_s = 1'b0;
        endcase
        in_range_s  = (cur_adr_s[AW-1:MEM_AW] == '0);
        mem_idx_s   = cur_adr_s[MEM_AW-1:0];
        lane_mask_s = lane_mask(cur_sel_s);
        if (in_range_s) begin
            rd_word_s = mem_r[mem_idx_s] & lane_mask_s;
        end else begin
            rd_word_s = '0;
        end
    end

    // Transfer FSM with registered ack/read data; an abort in WAIT leaves dat_o untouched
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            sel_r   <= '0;
            adr_r   <= '0;
            dat_r   <= '0;
            ack_o   <= 1'b0;
            dat_o   <= '0;
        end else begin
            ack_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        we_r    <= we_i;
                        sel_r   <= sel_i;
                        adr_r   <= adr_i;
                        dat_r   <= dat_i;
                        cnt_r   <= WAIT_CNT;
                        state_r <= go_ack_s ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!req_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                        if (go_ack_s) begin
                            state_r <= ST_ACK;
                        end
                    end
                end
                ST_ACK:  state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
            if (go_ack_s) begin
                ack_o <= 1'b1;
                if (!cur_we_s) begin
                    dat_o <= rd_word_s;
                end
            end
        end
    end

    // RAM contents are deliberately outside reset; a reset on the ACK-entry edge suppresses the write
    always_ff @(posedge clk_i) begin
        if (!rst_i && go_ack_s && cur_we_s && in_range_s) begin
            mem_r[mem_idx_s] <= (mem_r[mem_idx_s] & ~lane_mask_s) | (cur_dat_s & lane_mask_s);
        end
    end
endmodule

// File: tb/tb_wb_memory_slave.sv
// Self-checking bench: three slaves (WAIT=1, 3, 0) driven controller-style and
// compared every cycle against a transaction-level memory model.
module tb_wb_memory_slave;
    logic        clk;
    logic        rst   [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [1:0]  sel   [3];
    logic [14:0] adr   [3];
    logic [15:0] dat_i [3];
    logic [15:0] dat_o [3];
    logic        ack   [3];

    logic        exp_ack [3];
    logic [15:0] exp_dat [3];
    logic [15:0] mem [3][1024];

    int          tests = 0;
    int          fails = 0;
    bit          chk_en = 1'b0;
    bit          lit_on = 1'b0;
    int          lit_k = 0;
    logic [15:0] lit_exp = 16'h0000;
    string       lit_name = "";

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_memory_slave #(
            .WORD   (16),
            .MEM_AW (10),
            .WAIT   ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .clk_i (clk),
            .rst_i (rst[g]),
            .cyc_i (cyc[g]),
            .stb_i (stb[g]),
            .we_i  (we[g]),
            .sel_i (sel[g]),
            .adr_i (adr[g]),
            .dat_i (dat_i[g]),
            .ack_o (ack[g]),
            .dat_o (dat_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    function automatic logic [15:0] lanes(input logic [1:0] s);
        return (s[0] ? 16'h00FF : 16'h0000) | (s[1] ? 16'hFF00 : 16'h0000);
    endfunction

    function automatic logic [15:0] model_read(input int k, input logic [1:0] s, input logic [14:0] a);
        if (a > 15'd1023) return 16'h0000;
        return mem[k][a[9:0]] & lanes(s);
    endfunction

    task automatic model_write(input int k, input logic [1:0] s, input logic [14:0] a, input logic [15:0] d);
        if (a <= 15'd1023) mem[k][a[9:0]] = (mem[k][a[9:0]] & ~lanes(s)) | (d & lanes(s));
    endtask

    task automatic drive(input int k, input logic w, input logic [1:0] s, input logic [14:0] a, input logic [15:0] d);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; dat_i[k] = d;
    endtask

    // Complete transfer; inputs other than cyc/stb are scrambled after capture
    task automatic xfer(input int k, input logic w, input logic [1:0] s, input logic [14:0] a, input logic [15:0] d);
        int wt;
        wt = wait_of(k);
        drive(k, w, s, a, d);
        @(posedge clk); #1;
        we[k] = 1'($urandom); sel[k] = 2'($urandom); adr[k] = 15'($urandom); dat_i[k] = 16'($urandom);
        if (wt > 0) begin
            repeat (wt) @(posedge clk);
            #1;
        end
        exp_ack[k] = 1'b1;
        if (w) model_write(k, s, a, d);
        else   exp_dat[k] = model_read(k, s, a);
        @(posedge clk); #1;
        exp_ack[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    // Strobe dropped h edges after capture (h < WAIT): no ack, no effect
    task automatic abort_xfer(input int k, input logic w, input logic [1:0] s, input logic [14:0] a,
                              input logic [15:0] d, input int h);
        drive(k, w, s, a, d);
        @(posedge clk);
        repeat (h) @(posedge clk);
        #1; stb[k] = 1'b0;
        @(posedge clk); #1; cyc[k] = 1'b0;
        repeat (wait_of(k) + 1) @(posedge clk);
        #1;
    endtask

    // Reset high on the edge that would enter ACK (WAIT >= 1)
    task automatic rst_mid(input int k, input logic w, input logic [1:0] s, input logic [14:0] a, input logic [15:0] d);
        drive(k, w, s, a, d);
        @(posedge clk);
        repeat (wait_of(k) - 1) @(posedge clk);
        #1; rst[k] = 1'b1;
        @(posedge clk); #1;
        rst[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0; exp_dat[k] = 16'h0000;
        @(posedge clk); #1;
    endtask

    task automatic pin(input int k, input logic [15:0] v, input string nm);
        lit_k = k; lit_exp = v; lit_name = nm; lit_on = 1'b1;
        @(negedge clk); #1;
        lit_on = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (ack[k] !== exp_ack[k]) begin
                    fails++;
                    $display("FAIL ack[%0d] t=%0t got=%b exp=%b", k, $time, ack[k], exp_ack[k]);
                end
                tests++;
                if (dat_o[k] !== exp_dat[k]) begin
                    fails++;
                    $display("FAIL dat_o[%0d] t=%0t got=%h exp=%h", k, $time, dat_o[k], exp_dat[k]);
                end
            end
            if (lit_on) begin
                tests++;
                if (dat_o[lit_k] !== lit_exp) begin
                    fails++;
                    $display("FAIL %s dut[%0d] got=%h exp=%h", lit_name, lit_k, dat_o[lit_k], lit_exp);
                end
                tests++;
                if (exp_dat[lit_k] !== lit_exp) begin
                    fails++;
                    $display("FAIL %s model[%0d] got=%h exp=%h", lit_name, lit_k, exp_dat[lit_k], lit_exp);
                end
            end
        end
    end

    initial begin
        logic [14:0] a;
        logic [1:0]  s;
        logic        w;
        logic [15:0] d;
        int          r;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b0;
            sel[k] = 2'b11; adr[k] = 15'd0; dat_i[k] = 16'h0000;
            exp_ack[k] = 1'b0; exp_dat[k] = 16'h0000;
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
        end
        pin(0, 16'h0000, "reset_dat");

        // WAIT=1: full word, byte lanes, out of range, empty select
        xfer(0, 1'b1, 2'b11, 15'h0010, 16'hBEEF);
        xfer(0, 1'b0, 2'b11, 15'h0010, 16'h0000);
        pin(0, 16'hBEEF, "full_rd");
        xfer(0, 1'b1, 2'b01, 15'h0010, 16'h1234);
        xfer(0, 1'b0, 2'b10, 15'h0010, 16'h0000);
        pin(0, 16'hBE00, "lane_hi");
        xfer(0, 1'b0, 2'b01, 15'h0010, 16'h0000);
        pin(0, 16'h0034, "lane_lo");
        xfer(0, 1'b1, 2'b11, 15'h0410, 16'hAAAA);
        xfer(0, 1'b0, 2'b11, 15'h0010, 16'h0000);
        pin(0, 16'hBE34, "oor_wr");
        xfer(0, 1'b0, 2'b11, 15'h0410, 16'h0000);
        pin(0, 16'h0000, "oor_rd");
        xfer(0, 1'b1, 2'b00, 15'h0010, 16'hFFFF);
        xfer(0, 1'b0, 2'b11, 15'h0010, 16'h0000);
        pin(0, 16'hBE34, "sel0_wr");
        xfer(0, 1'b0, 2'b00, 15'h0010, 16'h0000);
        pin(0, 16'h0000, "sel0_rd");

        // WAIT=3: abort and mid-transfer reset
        xfer(1, 1'b1, 2'b11, 15'h0020, 16'h1111);
        xfer(1, 1'b1, 2'b11, 15'h0021, 16'h2222);
        xfer(1, 1'b0, 2'b11, 15'h0021, 16'h0000);
        abort_xfer(1, 1'b1, 2'b11, 15'h0020, 16'h5555, 1);
        abort_xfer(1, 1'b0, 2'b11, 15'h0020, 16'h0000, 0);
        pin(1, 16'h2222, "abort_rd_hold");
        xfer(1, 1'b0, 2'b11, 15'h0020, 16'h0000);
        pin(1, 16'h1111, "abort_wr");
        rst_mid(1, 1'b1, 2'b11, 15'h0020, 16'h7777);
        pin(1, 16'h0000, "rst_mid_dat");
        xfer(1, 1'b0, 2'b11, 15'h0020, 16'h0000);
        pin(1, 16'h1111, "rst_mid_wr");

        // WAIT=0: controller-style read, idle, read
        xfer(2, 1'b1, 2'b11, 15'h0001, 16'hA1A1);
        xfer(2, 1'b1, 2'b11, 15'h0002, 16'hB2B2);
        xfer(2, 1'b0, 2'b11, 15'h0001, 16'h0000);
        pin(2, 16'hA1A1, "w0_rd1");
        xfer(2, 1'b0, 2'b11, 15'h0002, 16'h0000);
        pin(2, 16'hB2B2, "w0_rd2");

        // Randomized traffic against the model
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) xfer(k, 1'b1, 2'b11, 15'(i), 16'($urandom));
            for (int i = 0; i < 150; i++) begin
                r = int'($urandom_range(0, 19));
                a = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(1024, 32767)) : 15'($urandom_range(0, 15));
                s = 2'($urandom);
                w = 1'($urandom);
                d = 16'($urandom);
                if (wait_of(k) > 0 && r < 2)       abort_xfer(k, w, s, a, d, int'($urandom_range(0, wait_of(k) - 1)));
                else if (wait_of(k) > 0 && r == 2) rst_mid(k, w, s, a, d);
                else                                xfer(k, w, s, a, d);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
